// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - interrupt controller with sync, level/edge mode, mask, W1C pending and status
module irq_controller #(
    parameter int NUM_SOURCES = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_BITS     = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_SOURCES-1:0] src_i,
    output logic [NUM_SOURCES-1:0] cpu_irq_o,
    input  logic [NUM_SOURCES-1:0] cpu_ack_i,
    input  logic                   req_i,
    input  logic                   nwr_i,
    input  logic [1:0]             address_i,
    input  logic [31:0]            data_in_i,
    output logic [31:0]            data_out_o,
    output logic                   ready_o
);

    localparam int N = NUM_SOURCES;

    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_MODE    = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic [N-1:0]       s;
    logic [N-1:0]       prev_q;
    logic [N-1:0]       edge_pending_q, edge_pending_d;
    logic [N-1:0]       enable_q, enable_d;
    logic [N-1:0]       mode_q, mode_d;
    logic [N-1:0]       cpu_irq_q, cpu_irq_d;
    logic [31:0]        data_out_q, data_out_d;
    logic               ready_q;
    logic               req_q;

    logic               execute, wr_en, rd_en;
    logic [N-1:0]       wdata, rise, pending, masked, clr, mode_fall;
    logic [ID_BITS-1:0] irq_id;
    logic [31:0]        status, rdata;
    logic               unused_data;

    assign unused_data = ^data_in_i;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = src_i;
        end else begin : g_sync
            logic [N-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= src_i;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        execute   = req_i & ~req_q;
        wr_en     = execute & ~nwr_i;
        rd_en     = execute & nwr_i;
        wdata     = data_in_i[N-1:0];
        rise      = s & ~prev_q;
        pending   = (mode_q & edge_pending_q) | (~mode_q & s);
        masked    = pending & enable_q;

        // Scan downwards so the lowest-numbered active source wins.
        irq_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) irq_id = ID_BITS'(i);
        end
        status              = '0;
        status[31]          = |masked;
        status[ID_BITS-1:0] = irq_id;

        enable_d  = enable_q;
        mode_d    = mode_q;
        clr       = cpu_ack_i;
        mode_fall = '0;
        if (wr_en) begin
            case (address_i)
                REG_ENABLE:  enable_d = wdata;
                REG_MODE: begin
                    mode_d    = wdata;
                    mode_fall = mode_q & ~wdata;
                end
                REG_PENDING: clr = clr | wdata;
                default: ;
            endcase
        end

        // A new edge beats ack/W1C; leaving edge mode always discards the latch.
        edge_pending_d = ((edge_pending_q & ~clr) | (mode_q & rise)) & ~mode_fall;

        rdata = '0;
        case (address_i)
            REG_ENABLE:  rdata[N-1:0] = enable_q;
            REG_MODE:    rdata[N-1:0] = mode_q;
            REG_PENDING: rdata[N-1:0] = pending;
            REG_STATUS:  rdata        = status;
            default: ;
        endcase

        data_out_d = rd_en ? rdata : data_out_q;
        cpu_irq_d  = masked;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q         <= '0;
            edge_pending_q <= '0;
            enable_q       <= '0;
            mode_q         <= '0;
            cpu_irq_q      <= '0;
            data_out_q     <= '0;
            ready_q        <= 1'b0;
            req_q          <= 1'b0;
        end else begin
            prev_q         <= s;
            edge_pending_q <= edge_pending_d;
            enable_q       <= enable_d;
            mode_q         <= mode_d;
            cpu_irq_q      <= cpu_irq_d;
            data_out_q     <= data_out_d;
            ready_q        <= req_i;
            req_q          <= req_i;
        end
    end

    assign cpu_irq_o  = cpu_irq_q;
    assign data_out_o = data_out_q;
    assign ready_o    = ready_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [7:0]  src_i;
    logic [7:0]  cpu_irq_o;
    logic [7:0]  cpu_ack_i;
    logic        req_i;
    logic        nwr_i;
    logic [1:0]  address_i;
    logic [31:0] data_in_i;
    logic [31:0] data_out_o;
    logic        ready_o;

    int tests  = 0;
    int failed = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    irq_controller #(.NUM_SOURCES(8), .SYNC_STAGES(2), .ID_BITS(5)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .src_i      (src_i),
        .cpu_irq_o  (cpu_irq_o),
        .cpu_ack_i  (cpu_ack_i),
        .req_i      (req_i),
        .nwr_i      (nwr_i),
        .address_i  (address_i),
        .data_in_i  (data_in_i),
        .data_out_o (data_out_o),
        .ready_o    (ready_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        req_i = 1'b1; nwr_i = 1'b0; address_i = a; data_in_i = d;
        tick(1);
        req_i = 1'b0; nwr_i = 1'b1;
        tick(1);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        req_i = 1'b1; nwr_i = 1'b1; address_i = a;
        tick(1);
        d = data_out_o;
        req_i = 1'b0;
        tick(1);
    endtask

    initial begin
        reset_i = 1'b1; src_i = '0; cpu_ack_i = '0;
        req_i = 1'b0; nwr_i = 1'b1; address_i = '0; data_in_i = '0;
        tick(2);
        check("reset_cpu_irq", {24'h0, cpu_irq_o}, 32'h0);
        check("reset_ready", {31'h0, ready_o}, 32'h0);
        check("reset_data_out", data_out_o, 32'h0);
        reset_i = 1'b0;
        tick(1);

        // Level mode
        bus_write(2'd0, 32'h01);
        src_i = 8'h01;
        tick(2);
        check("level_latency_early", {24'h0, cpu_irq_o}, 32'h00);
        tick(1);
        check("level_raise", {24'h0, cpu_irq_o}, 32'h01);
        cpu_ack_i = 8'h01; tick(1); cpu_ack_i = '0; tick(1);
        check("level_ack_no_effect", {24'h0, cpu_irq_o}, 32'h01);
        src_i = 8'h00;
        tick(2);
        check("level_drop_early", {24'h0, cpu_irq_o}, 32'h01);
        tick(1);
        check("level_drop", {24'h0, cpu_irq_o}, 32'h00);
        bus_read(2'd2, rd);
        check("level_pending_zero", rd, 32'h0);

        // Edge mode
        bus_write(2'd1, 32'h02);
        bus_write(2'd0, 32'h02);
        src_i = 8'h02; tick(1); src_i = 8'h00;
        tick(2);
        check("edge_latency_early", {24'h0, cpu_irq_o}, 32'h00);
        tick(1);
        check("edge_latch", {24'h0, cpu_irq_o}, 32'h02);
        tick(3);
        check("edge_held", {24'h0, cpu_irq_o}, 32'h02);
        bus_read(2'd2, rd);
        check("edge_pending", rd, 32'h02);
        bus_read(2'd3, rd);
        check("edge_status", rd, 32'h80000001);
        cpu_ack_i = 8'h02; tick(1); cpu_ack_i = '0; tick(1);
        check("edge_ack_clear", {24'h0, cpu_irq_o}, 32'h00);
        bus_read(2'd2, rd);
        check("edge_pending_cleared", rd, 32'h0);

        // Rise coincident with ack: set wins
        src_i = 8'h02; tick(1); src_i = 8'h00; tick(1);
        cpu_ack_i = 8'h02; tick(1); cpu_ack_i = '0; tick(1);
        check("ack_vs_rise_irq", {24'h0, cpu_irq_o}, 32'h02);
        bus_read(2'd2, rd);
        check("ack_vs_rise_pending", rd, 32'h02);

        // Rise coincident with W1C: set wins
        src_i = 8'h02; tick(1); src_i = 8'h00; tick(1);
        bus_write(2'd2, 32'h02);
        bus_read(2'd2, rd);
        check("w1c_vs_rise_pending", rd, 32'h02);
        bus_write(2'd2, 32'h02);
        bus_read(2'd2, rd);
        check("w1c_clear", rd, 32'h0);

        // Mask and priority
        bus_write(2'd1, 32'hFF);
        bus_write(2'd0, 32'h28);
        src_i = 8'h68; tick(1); src_i = 8'h00;
        tick(4);
        check("mask_cpu_irq", {24'h0, cpu_irq_o}, 32'h28);
        bus_read(2'd3, rd);
        check("mask_status", rd, 32'h80000003);
        bus_read(2'd2, rd);
        check("mask_pending", rd, 32'h68);
        bus_write(2'd0, 32'hFFFFFFFF);
        check("unmask_cpu_irq", {24'h0, cpu_irq_o}, 32'h68);
        bus_read(2'd0, rd);
        check("enable_upper_bits_zero", rd, 32'h000000FF);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd);
        check("status_write_ignored", rd, 32'h80000003);

        // Held req: single W1C; an edge on cycle 3 survives
        src_i = 8'h08;
        req_i = 1'b1; nwr_i = 1'b0; address_i = 2'd2; data_in_i = 32'h08;
        check("held_ready_before", {31'h0, ready_o}, 32'h0);
        tick(1);
        src_i = 8'h00;
        check("held_ready_c1", {31'h0, ready_o}, 32'h1);
        tick(4);
        check("held_ready_c5", {31'h0, ready_o}, 32'h1);
        req_i = 1'b0; nwr_i = 1'b1;
        tick(1);
        check("held_ready_drop", {31'h0, ready_o}, 32'h0);
        bus_read(2'd2, rd);
        check("held_single_clear", rd, 32'h68);

        // Leaving edge mode discards the latched edge
        bus_write(2'd1, 32'hF7);
        bus_write(2'd1, 32'hFF);
        bus_read(2'd2, rd);
        check("mode_fall_clears", rd, 32'h60);

        // Reset in the middle of a read
        src_i = 8'hFF; tick(1); src_i = 8'h00;
        tick(4);
        check("pre_reset_irq", {24'h0, cpu_irq_o}, 32'hFF);
        req_i = 1'b1; nwr_i = 1'b1; address_i = 2'd2;
        tick(1);
        check("pre_reset_ready", {31'h0, ready_o}, 32'h1);
        check("pre_reset_data", data_out_o, 32'hFF);
        reset_i = 1'b1;
        #1;
        check("async_reset_irq", {24'h0, cpu_irq_o}, 32'h0);
        check("async_reset_ready", {31'h0, ready_o}, 32'h0);
        check("async_reset_data", data_out_o, 32'h0);
        src_i = 8'h01;
        tick(1);
        reset_i = 1'b0;
        tick(1);
        check("post_reset_new_access", {31'h0, ready_o}, 32'h1);
        req_i = 1'b0;
        tick(5);
        check("post_reset_masked", {24'h0, cpu_irq_o}, 32'h0);
        bus_read(2'd1, rd);
        check("post_reset_mode", rd, 32'h0);
        bus_read(2'd2, rd);
        check("post_reset_level_pending", rd, 32'h01);
        bus_write(2'd0, 32'h01);
        check("post_reset_reenable", {24'h0, cpu_irq_o}, 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
